spi_flash_xip_ctrl: RTL and testbench

Read-only SPI flash controller that shares the boot flash between two requesters, typically instruction fetch (port 0) and data/load path (port 1). It arbitrates round-robin and sequences a standard SPI READ (0x03) command, a 24-bit address and a 32-bit data phase, driving the flash pins directly in SPI mode 0. It sits inside soc_top between the CPU fetch/load paths and the spi_cs/spi_clk/spi_mosi/spi_miso pads. Read data is returned as a little-endian 32-bit word.

---
 rtl/spi_flash_xip_ctrl.sv | 161 ++++++++++++++++
 tb/tb_spi_flash_xip_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_xip_ctrl.sv
`default_nettype none
// spi_flash_xip_ctrl: two-port round-robin read-only SPI flash controller.
// Issues READ (0x03) + 24-bit address + 32 data bits in SPI mode 0.
module spi_flash_xip_ctrl #(
   parameter int CLK_DIV = 2,
   parameter int CS_IDLE = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   input  logic [24:0] req0_addr,
   output logic        req0_ready,
   output logic        resp0_valid,
   output logic [31:0] resp0_data,
   input  logic        req1_valid,
   input  logic [24:0] req1_addr,
   output logic        req1_ready,
   output logic        resp1_valid,
   output logic [31:0] resp1_data,
   output logic        spi_clk,
   output logic [1:0]  spi_cs,
   output logic        spi_mosi,
   input  logic        spi_miso
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int GAP_W = (CS_IDLE > 1) ? $clog2(CS_IDLE) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_IDLE - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, GAP = 2'd2} state_t;

   state_t             state_q, state_d;
   logic               rr_q, rr_d;
   logic               gnt_q, gnt_d;
   logic [5:0]         bit_q, bit_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [GAP_W-1:0]   gap_q, gap_d;
   logic               sclk_q, sclk_d;
   logic [1:0]         cs_q, cs_d;
   logic [31:0]        tx_q, tx_d;
   logic [31:0]        rx_q, rx_d;
   logic [1:0]         rvalid_q, rvalid_d;
   logic [31:0]        rdata0_q, rdata0_d;
   logic [31:0]        rdata1_q, rdata1_d;

   logic               w_gnt0, w_gnt1;
   logic [24:0]        w_addr;
   logic [31:0]        w_word;

   // rr_q=1 gives port 1 priority when both request
   assign w_gnt1 = req1_valid & (~req0_valid | rr_q);
   assign w_gnt0 = req0_valid & ~w_gnt1;
   assign w_addr = w_gnt1 ? req1_addr : req0_addr;
   // First byte received lands in the least significant byte
   assign w_word = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};

   assign req0_ready  = ~rst & (state_q == IDLE) & w_gnt0;
   assign req1_ready  = ~rst & (state_q == IDLE) & w_gnt1;
   assign resp0_valid = rvalid_q[0];
   assign resp1_valid = rvalid_q[1];
   assign resp0_data  = rdata0_q;
   assign resp1_data  = rdata1_q;
   assign spi_clk     = sclk_q;
   assign spi_cs      = cs_q;
   assign spi_mosi    = tx_q[31];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         rr_q     <= 1'b0;
         gnt_q    <= 1'b0;
         bit_q    <= '0;
         div_q    <= '0;
         gap_q    <= '0;
         sclk_q   <= 1'b0;
         cs_q     <= 2'b11;
         tx_q     <= '0;
         rx_q     <= '0;
         rvalid_q <= 2'b00;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         state_q  <= state_d;
         rr_q     <= rr_d;
         gnt_q    <= gnt_d;
         bit_q    <= bit_d;
         div_q    <= div_d;
         gap_q    <= gap_d;
         sclk_q   <= sclk_d;
         cs_q     <= cs_d;
         tx_q     <= tx_d;
         rx_q     <= rx_d;
         rvalid_q <= rvalid_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      rr_d     = rr_q;
      gnt_d    = gnt_q;
      bit_d    = bit_q;
      div_d    = div_q;
      gap_d    = gap_q;
      sclk_d   = sclk_q;
      cs_d     = cs_q;
      tx_d     = tx_q;
      rx_d     = rx_q;
      rvalid_d = 2'b00;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      case (state_q)
         IDLE: begin
            if (w_gnt0 | w_gnt1) begin
               gnt_d   = w_gnt1;
               rr_d    = ~w_gnt1;
               cs_d    = w_addr[24] ? 2'b01 : 2'b10;
               tx_d    = {8'h03, w_addr[23:0]};
               bit_d   = '0;
               div_d   = '0;
               sclk_d  = 1'b0;
               state_d = XFER;
            end
         end
         XFER: begin
            if (div_q == DIV_LAST) begin
               div_d = '0;
               if (!sclk_q) begin
                  sclk_d = 1'b1;
                  rx_d   = {rx_q[30:0], spi_miso};
               end else begin
                  sclk_d = 1'b0;
                  if (bit_q == 6'd63) begin
                     cs_d            = 2'b11;
                     gap_d           = '0;
                     state_d         = GAP;
                     rvalid_d[gnt_q] = 1'b1;
                     if (gnt_q) rdata1_d = w_word;
                     else       rdata0_d = w_word;
                  end else begin
                     // Zeros shift in behind the address, so MOSI is 0 in the data phase
                     bit_d = bit_q + 6'd1;
                     tx_d  = {tx_q[30:0], 1'b0};
                  end
               end
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         GAP: begin
            if (gap_q == GAP_LAST) state_d = IDLE;
            else                   gap_d   = gap_q + GAP_W'(1);
         end
         default: state_d = IDLE;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_xip_ctrl.sv
`default_nettype none
// Directed bench for spi_flash_xip_ctrl: CLK_DIV=2 instance (a) and CLK_DIV=1 instance (b),
// each attached to a behavioural SPI flash model.
module tb_spi_flash_xip_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic [24:0] req0_addr = '0, req1_addr = '0;
   logic        req0_ready, req1_ready, resp0_valid, resp1_valid;
   logic [31:0] resp0_data, resp1_data;
   logic        sclk_a, mosi_a;
   logic [1:0]  spi_cs;
   logic        miso_a = 1'b0;

   logic        vb = 1'b0, vb1 = 1'b0;
   logic [24:0] ab = '0, ab1 = '0;
   logic        readyb, ready1b, respb, resp1b, sclk_b, mosi_b;
   logic [31:0] datab, data1b;
   logic [1:0]  cs_b;
   logic        miso_b = 1'b0;

   int npass = 0, nchk = 0;

   spi_flash_xip_ctrl #(.CLK_DIV(2), .CS_IDLE(4)) dut_a (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
      .resp0_valid(resp0_valid), .resp0_data(resp0_data),
      .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
      .resp1_valid(resp1_valid), .resp1_data(resp1_data),
      .spi_clk(sclk_a), .spi_cs(spi_cs), .spi_mosi(mosi_a), .spi_miso(miso_a));

   spi_flash_xip_ctrl #(.CLK_DIV(1), .CS_IDLE(4)) dut_b (
      .clk(clk), .rst(rst),
      .req0_valid(vb), .req0_addr(ab), .req0_ready(readyb),
      .resp0_valid(respb), .resp0_data(datab),
      .req1_valid(vb1), .req1_addr(ab1), .req1_ready(ready1b),
      .resp1_valid(resp1b), .resp1_data(data1b),
      .spi_clk(sclk_b), .spi_cs(cs_b), .spi_mosi(mosi_b), .spi_miso(miso_b));

   // Flash contents: chip 0 0x100..0x103 = 13 05 00 00, elsewhere an address-derived pattern
   function automatic logic [7:0] fbyte(input logic chip, input logic [23:0] a);
      if (!chip && a == 24'h000100) return 8'h13;
      if (!chip && a == 24'h000101) return 8'h05;
      if (!chip && (a == 24'h000102 || a == 24'h000103)) return 8'h00;
      return a[7:0] ^ (chip ? 8'hA5 : 8'h3C);
   endfunction

   function automatic logic fbit(input logic chip, input logic [23:0] a, input logic [6:0] k);
      logic [7:0] b;
      b = fbyte(chip, a + 24'(k[4:3]));
      return b[3'd7 - k[2:0]];
   endfunction

   logic [6:0]  fcnt_a, fcnt_b;
   logic [31:0] fcmd_a, fmo_a, fcmd_b, fmo_b;
   logic        fchip_a, fchip_b;

   always @(posedge sclk_a or negedge spi_cs[0] or negedge spi_cs[1]) begin
      if (!sclk_a) begin
         fcnt_a  <= 7'd0;
         fchip_a <= spi_cs[0];
      end else if (spi_cs != 2'b11) begin
         if (fcnt_a < 7'd32) fcmd_a <= {fcmd_a[30:0], mosi_a};
         else                fmo_a  <= {fmo_a[30:0], mosi_a};
         fcnt_a <= fcnt_a + 7'd1;
      end
   end
   always @(negedge sclk_a)
      if (spi_cs != 2'b11 && fcnt_a >= 7'd32 && fcnt_a < 7'd64)
         miso_a <= fbit(fchip_a, fcmd_a[23:0], fcnt_a - 7'd32);

   always @(posedge sclk_b or negedge cs_b[0] or negedge cs_b[1]) begin
      if (!sclk_b) begin
         fcnt_b  <= 7'd0;
         fchip_b <= cs_b[0];
      end else if (cs_b != 2'b11) begin
         if (fcnt_b < 7'd32) fcmd_b <= {fcmd_b[30:0], mosi_b};
         else                fmo_b  <= {fmo_b[30:0], mosi_b};
         fcnt_b <= fcnt_b + 7'd1;
      end
   end
   always @(negedge sclk_b)
      if (cs_b != 2'b11 && fcnt_b >= 7'd32 && fcnt_b < 7'd64)
         miso_b <= fbit(fchip_b, fcmd_b[23:0], fcnt_b - 7'd32);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called in the cycle after accept (n=1); returns n at the response cycle of instance a
   task automatic wait_resp(input int port, output int n, output logic [1:0] cs_acc,
                            output logic rdy_other);
      n = 1;
      cs_acc = spi_cs;
      rdy_other = 1'b0;
      while (((port == 0) ? resp0_valid : resp1_valid) !== 1'b1 && n < 400) begin
         tick();
         n++;
         cs_acc &= spi_cs;
         if ((port == 0) ? req1_ready : req0_ready) rdy_other = 1'b1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      int n, c;
      logic [1:0] acc;
      logic ro, seen;

      // Reset state, including ready held low while rst is asserted
      repeat (2) @(posedge clk);
      #1;
      req0_valid = 1'b1;
      #1;
      chk("ready_in_reset", 32'(req0_ready), 32'd0);
      req0_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("rst_cs", 32'(spi_cs), 32'h3);
      chk("rst_sclk", 32'(sclk_a), 32'd0);
      chk("rst_mosi", 32'(mosi_a), 32'd0);
      chk("rst_resp", 32'({resp0_valid, resp1_valid}), 32'd0);
      chk("rst_data0", resp0_data, 32'd0);
      chk("rst_data1", resp1_data, 32'd0);

      // Single read, port 0, addr 0x100
      req0_valid = 1'b1;
      req0_addr = 25'h0000100;
      #1;
      chk("t1_ready0", 32'(req0_ready), 32'd1);
      tick();
      req0_valid = 1'b0;
      chk("t1_cs_low", 32'(spi_cs), 32'h2);
      chk("t1_bit0", 32'({sclk_a, mosi_a}), 32'd0);
      wait_resp(0, n, acc, ro);
      chk("t1_latency", 32'(n), 32'd257);
      chk("t1_data", resp0_data, 32'h00000513);
      chk("t1_cs_acc", 32'(acc), 32'h2);
      chk("t1_cs_end", 32'({spi_cs, sclk_a}), 32'h6);
      chk("t1_cmd", fcmd_a, 32'h03000100);
      chk("t1_mosi_data", fmo_a, 32'd0);
      tick();
      chk("t1_pulse", 32'(resp0_valid), 32'd0);
      chk("t1_hold", resp0_data, 32'h00000513);

      // Simultaneous requests after reset: port 0 then port 1
      do_reset();
      req0_valid = 1'b1;
      req0_addr = 25'h0000000;
      req1_valid = 1'b1;
      req1_addr = 25'h0000004;
      #1;
      chk("t2_ready", 32'({req1_ready, req0_ready}), 32'h1);
      tick();
      req0_valid = 1'b0;
      wait_resp(0, n, acc, ro);
      chk("t2_lat0", 32'(n), 32'd257);
      chk("t2_data0", resp0_data, 32'h3F3E3D3C);
      chk("t2_no_ready1", 32'(ro), 32'd0);
      c = 0;
      while (!req1_ready && c < 20) begin
         tick();
         c++;
      end
      chk("t2_gap", 32'(c), 32'd4);
      tick();
      req1_valid = 1'b0;
      wait_resp(1, n, acc, ro);
      chk("t2_lat1", 32'(n), 32'd257);
      chk("t2_data1", resp1_data, 32'h3B3A3938);
      chk("t2_cs_acc", 32'(acc), 32'h2);

      // Both held valid: grants alternate; port 1 targets chip 1
      req0_valid = 1'b1;
      req0_addr = 25'h0000000;
      req1_valid = 1'b1;
      req1_addr = 25'h1000010;
      #1;
      for (int k = 0; k < 4; k++) begin
         c = 0;
         while (!(req0_ready | req1_ready) && c < 300) begin
            tick();
            c++;
         end
         chk("t4_spacing", 32'(c), (k == 0) ? 32'd4 : 32'd260);
         chk("t4_port", 32'({req1_ready, req0_ready}), (k % 2 == 1) ? 32'h2 : 32'h1);
         tick();
         chk("t4_cs", 32'(spi_cs), (k % 2 == 1) ? 32'h1 : 32'h2);
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      wait_resp(1, n, acc, ro);
      chk("t4_lat1", 32'(n), 32'd257);
      chk("t4_cs_acc", 32'(acc), 32'h1);
      chk("t4_data1", resp1_data, 32'hB6B7B4B5);
      chk("t4_cmd", fcmd_a, 32'h03000010);
      chk("t4_data0", resp0_data, 32'h3F3E3D3C);

      // CLK_DIV=1 instance
      vb = 1'b1;
      ab = 25'h0000100;
      #1;
      chk("t5_ready", 32'(readyb), 32'd1);
      tick();
      vb = 1'b0;
      chk("t5_sclk1", 32'({cs_b, sclk_b}), 32'h4);
      tick();
      chk("t5_sclk2", 32'(sclk_b), 32'd1);
      tick();
      chk("t5_sclk3", 32'(sclk_b), 32'd0);
      n = 3;
      while (!respb && n < 200) begin
         tick();
         n++;
      end
      chk("t5_latency", 32'(n), 32'd129);
      chk("t5_data", datab, 32'h00000513);
      chk("t5_cmd", fcmd_b, 32'h03000100);

      // Asynchronous reset during bit 30, then a fresh read
      req0_valid = 1'b1;
      req0_addr = 25'h0000100;
      #1;
      chk("t6_ready", 32'(req0_ready), 32'd1);
      tick();
      req0_valid = 1'b0;
      repeat (120) tick();
      chk("t6_mid_cs", 32'(spi_cs), 32'h2);
      #3;
      rst = 1'b1;
      #1;
      chk("t6_async", 32'({spi_cs, sclk_a, mosi_a}), 32'hC);
      @(posedge clk);
      #1;
      rst = 1'b0;
      seen = 1'b0;
      repeat (150) begin
         tick();
         if (resp0_valid | resp1_valid | (spi_cs != 2'b11)) seen = 1'b1;
      end
      chk("t6_no_resp", 32'(seen), 32'd0);
      req1_valid = 1'b1;
      req1_addr = 25'h0000004;
      #1;
      chk("t6_ready1", 32'(req1_ready), 32'd1);
      tick();
      req1_valid = 1'b0;
      wait_resp(1, n, acc, ro);
      chk("t6_lat", 32'(n), 32'd257);
      chk("t6_data", resp1_data, 32'h3B3A3938);

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
`default_nettype wire
